washer_sequencer: RTL and testbench

Upstream controller for the station's washer pick-and-place hardware. It drives `controlEM` and `controlServo` into the PWM stage, which turns them into electromagnet and servo PWM waveforms. On a start request it runs a timed pickup sequence (lower, energize, raise, hold) or a timed drop sequence (lower, release, raise). It reports busy, done, holding and error status to the station system.

---
 rtl/washer_sequencer_if.sv | 32 +++
 rtl/washer_sequencer.sv | 179 +++++++++++++++++
 tb/tb_washer_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/washer_sequencer_if.sv
// Station-side bundle for washer_sequencer: request/abort in, arm/magnet control and status out.
// washerSense is present only when WASHER_SENSE_EN is defined.
interface washer_sequencer_if;
    logic start;
    logic op;
    logic abort;
`ifdef WASHER_SENSE_EN
    logic washerSense;
`endif
    logic controlEM;
    logic controlServo;
    logic busy;
    logic holding;
    logic done;
    logic err;

    modport master (
        output start, op, abort,
        input  controlEM, controlServo, busy, holding, done, err
`ifdef WASHER_SENSE_EN
        , output washerSense
`endif
    );

    modport slave (
        input  start, op, abort,
        output controlEM, controlServo, busy, holding, done, err
`ifdef WASHER_SENSE_EN
        , input washerSense
`endif
    );
endinterface

// File: rtl/washer_sequencer.sv
// Timed pickup/drop sequencer driving the electromagnet and servo PWM stage.
// Optional WASHER_SENSE_EN adds washer-present sensing with bounded pickup retries.
module washer_sequencer #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned T_LOWER   = 500,
    parameter int unsigned T_GRAB    = 300,
    parameter int unsigned T_RAISE   = 500,
    parameter int unsigned T_RELEASE = 300,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic               CLK,
    input  logic               RST,
    washer_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, P_LOWER, P_GRAB, P_RAISE, HOLD, D_LOWER, D_RELEASE, D_RAISE
    } state_t;

    localparam int unsigned PS_W = $clog2(TICK_DIV);

    // A zero dwell still spends one full ms tick in the state.
    localparam logic [15:0] TL_EFF  = (T_LOWER   == 0) ? 16'd1 : 16'(T_LOWER);
    localparam logic [15:0] TG_EFF  = (T_GRAB    == 0) ? 16'd1 : 16'(T_GRAB);
    localparam logic [15:0] TR_EFF  = (T_RAISE   == 0) ? 16'd1 : 16'(T_RAISE);
    localparam logic [15:0] TRL_EFF = (T_RELEASE == 0) ? 16'd1 : 16'(T_RELEASE);

    state_t          state, state_nxt;
    logic [PS_W-1:0] presc;
    logic [15:0]     ms;
    logic [15:0]     dwell_last;
    logic            timed, tick_wrap, dwell_end;
    logic            done_nxt, err_nxt;
    logic            em_nxt, servo_nxt, busy_nxt, hold_nxt;
    logic            em_q, servo_q, busy_q, hold_q, done_q, err_q;

`ifdef WASHER_SENSE_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    logic [RETRY_W-1:0] retries;
    logic               retry_inc;
`endif

    assign timed     = (state != IDLE) && (state != HOLD);
    assign tick_wrap = (presc == PS_W'(TICK_DIV - 1));
    assign dwell_end = tick_wrap && (ms == dwell_last);

    always_comb begin
        unique case (state)
            P_LOWER, D_LOWER: dwell_last = TL_EFF - 16'd1;
            P_GRAB:           dwell_last = TG_EFF - 16'd1;
            P_RAISE, D_RAISE: dwell_last = TR_EFF - 16'd1;
            D_RELEASE:        dwell_last = TRL_EFF - 16'd1;
            default:          dwell_last = 16'd0;
        endcase
    end

    // State register, dwell counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            presc   <= '0;
            ms      <= 16'd0;
            em_q    <= 1'b0;
            servo_q <= 1'b1;
            busy_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || !timed) begin
                presc <= '0;
                ms    <= 16'd0;
            end else if (tick_wrap) begin
                presc <= '0;
                ms    <= ms + 16'd1;
            end else begin
                presc <= presc + PS_W'(1);
            end
            em_q    <= em_nxt;
            servo_q <= servo_nxt;
            busy_q  <= busy_nxt;
            hold_q  <= hold_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

`ifdef WASHER_SENSE_EN
    always_ff @(posedge CLK) begin
        if (RST || (state_nxt == IDLE) || (state_nxt == HOLD))
            retries <= '0;
        else if (retry_inc)
            retries <= retries + RETRY_W'(1);
    end
`endif

    // Next state plus the done/err pulse that accompanies each transition.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
`ifdef WASHER_SENSE_EN
        retry_inc = 1'b0;
`endif
        case (state)
            IDLE: if (bus.start) begin
                if (!bus.op) state_nxt = P_LOWER;
                else         err_nxt   = 1'b1;
            end
            HOLD: if (bus.start) begin
                if (bus.op)  state_nxt = D_LOWER;
                else         err_nxt   = 1'b1;
            end
            default: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (dwell_end) begin
                    case (state)
                        P_LOWER:   state_nxt = P_GRAB;
                        P_GRAB:    state_nxt = P_RAISE;
                        P_RAISE: begin
`ifdef WASHER_SENSE_EN
                            if (bus.washerSense) begin
                                state_nxt = HOLD;
                                done_nxt  = 1'b1;
                            end else if (retries < RETRY_W'(MAX_RETRY)) begin
                                state_nxt = P_LOWER;
                                retry_inc = 1'b1;
                            end else begin
                                state_nxt = IDLE;
                                err_nxt   = 1'b1;
                            end
`else
                            state_nxt = HOLD;
                            done_nxt  = 1'b1;
`endif
                        end
                        D_LOWER:   state_nxt = D_RELEASE;
                        D_RELEASE: state_nxt = D_RAISE;
                        D_RAISE: begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                        default:   state_nxt = state;
                    endcase
                end
            end
        endcase
    end

    // Level outputs decoded from the next state so they move on the same edge.
    always_comb begin
        em_nxt    = 1'b0;
        servo_nxt = 1'b1;
        busy_nxt  = 1'b1;
        hold_nxt  = 1'b0;
        unique case (state_nxt)
            IDLE:      begin em_nxt = 1'b0; servo_nxt = 1'b1; busy_nxt = 1'b0; end
            P_LOWER:   begin em_nxt = 1'b0; servo_nxt = 1'b0; end
            P_GRAB:    begin em_nxt = 1'b1; servo_nxt = 1'b0; end
            P_RAISE:   begin em_nxt = 1'b1; servo_nxt = 1'b1; end
            HOLD:      begin em_nxt = 1'b1; servo_nxt = 1'b1; busy_nxt = 1'b0; hold_nxt = 1'b1; end
            D_LOWER:   begin em_nxt = 1'b1; servo_nxt = 1'b0; end
            D_RELEASE: begin em_nxt = 1'b0; servo_nxt = 1'b0; end
            D_RAISE:   begin em_nxt = 1'b0; servo_nxt = 1'b1; end
            default:   begin em_nxt = 1'b0; servo_nxt = 1'b1; busy_nxt = 1'b0; end
        endcase
    end

    assign bus.controlEM    = em_q;
    assign bus.controlServo = servo_q;
    assign bus.busy         = busy_q;
    assign bus.holding      = hold_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_washer_sequencer.sv
// Randomized scoreboard bench for washer_sequencer: expected done/err pulses are queued by the
// driver from a phase-timing model and matched by an independent monitor.
module tb_washer_sequencer;
    localparam int TD  = 4;
    localparam int TL  = 3;
    localparam int TG  = 2;
    localparam int TR  = 3;
    localparam int TRL = 2;
    localparam int MR  = 2;
    localparam int PU  = (TL + TG + TR) * TD;
    localparam int PD  = (TL + TRL + TR) * TD;
    localparam logic [3:0] LV_IDLE = 4'b0100;
    localparam logic [3:0] LV_HOLD = 4'b1101;

    typedef struct {
        bit is_err;
        int at;
    } ev_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mst = 1'b0;
    ev_t  expq[$];

    washer_sequencer_if bus();

    washer_sequencer #(
        .TICK_DIV(TD), .T_LOWER(TL), .T_GRAB(TG), .T_RAISE(TR),
        .T_RELEASE(TRL), .MAX_RETRY(MR)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every done/err pulse must match the head of the expectation queue.
    always @(negedge CLK) begin
        ev_t e;
        if (!RST) begin
            while (expq.size() > 0 && expq[0].at < cyc) begin
                e = expq.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_pulse: nothing seen, required %s at edge %0d", e.is_err ? "err" : "done", e.at);
            end
            if (bus.done || bus.err) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse at edge %0d: done=%b err=%b, required none", cyc, bus.done, bus.err);
                end else begin
                    e = expq.pop_front();
                    if (e.at != cyc || bus.err != e.is_err || bus.done != !e.is_err) begin
                        failures++;
                        $display("FAIL pulse at edge %0d: done=%b err=%b, required %s at edge %0d",
                                 cyc, bus.done, bus.err, e.is_err ? "err" : "done", e.at);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push_ev(bit is_err, int at);
        ev_t e;
        e.is_err = is_err;
        e.at     = at;
        expq.push_back(e);
    endtask

    function automatic logic [3:0] lv();
        return {bus.controlEM, bus.controlServo, bus.busy, bus.holding};
    endfunction

    task automatic chk(string nm, logic [3:0] got, logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: em/servo/busy/hold=%b, required %b", nm, cyc, got, exp);
        end
    endtask

    // Pickup: succ is the attempt on which the washer is sensed (0 = never); ab/nz are the
    // cycle offsets of an abort and of a stray start while busy (-1 or out of range = none).
    task automatic do_pickup(int succ, int ab, int nz);
        int  total, n;
        bit  ok;
`ifdef WASHER_SENSE_EN
        ok = (succ >= 1 && succ <= MR + 1);
        n  = ok ? succ : MR + 1;
`else
        ok = 1'b1;
        n  = 1;
`endif
        total = n * PU;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int t = 0; t < total; t++) begin
            int a;
            int d;
            a = t / PU + 1;
            d = t % PU;
`ifdef WASHER_SENSE_EN
            bus.washerSense = (a == succ);
`endif
            chk("pickup_levels", lv(), {d >= TL * TD, d >= (TL + TG) * TD, 2'b10});
            bus.start = (t == nz);
            bus.op    = 1'($urandom_range(0, 1));
            if (t == ab) begin
                bus.abort = 1'b1;
                push_ev(1'b1, cyc + 1);
                tick();
                bus.abort = 1'b0;
                bus.start = 1'b0;
                chk("pickup_abort", lv(), LV_IDLE);
                mst = 1'b0;
                return;
            end
            if (t == total - 1) push_ev(!ok, cyc + 1);
            tick();
        end
        bus.start = 1'b0;
`ifdef WASHER_SENSE_EN
        bus.washerSense = 1'b0;
`endif
        chk("pickup_end", lv(), ok ? LV_HOLD : LV_IDLE);
        mst = ok;
    endtask

    task automatic do_drop(int ab, int nz);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int t = 0; t < PD; t++) begin
            chk("drop_levels", lv(), {t < TL * TD, t >= (TL + TRL) * TD, 2'b10});
            bus.start = (t == nz);
            bus.op    = 1'($urandom_range(0, 1));
            if (t == ab) begin
                bus.abort = 1'b1;
                push_ev(1'b1, cyc + 1);
                tick();
                bus.abort = 1'b0;
                bus.start = 1'b0;
                chk("drop_abort", lv(), LV_IDLE);
                mst = 1'b0;
                return;
            end
            if (t == PD - 1) push_ev(1'b0, cyc + 1);
            tick();
        end
        bus.start = 1'b0;
        chk("drop_end", lv(), LV_IDLE);
        mst = 1'b0;
    endtask

    // Wrong-direction request: err pulse, state unchanged.
    task automatic illegal();
        bus.start = 1'b1;
        bus.op    = !mst;
        push_ev(1'b1, cyc + 1);
        tick();
        bus.start = 1'b0;
        chk("illegal_state", lv(), mst ? LV_HOLD : LV_IDLE);
        tick();
        chk("illegal_after", lv(), mst ? LV_HOLD : LV_IDLE);
    endtask

    task automatic abort_ignored();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_ignored", lv(), mst ? LV_HOLD : LV_IDLE);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.abort = 1'b0;
`ifdef WASHER_SENSE_EN
        bus.washerSense = 1'b0;
`endif
        RST = 1'b1;
        tick();
        tick();
        chk("reset_levels", lv(), LV_IDLE);
        RST = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 10 == 0) chk("idle_levels", lv(), LV_IDLE);
        end

        do_pickup(1, -1, -1);
        do_drop(-1, -1);
        illegal();
        do_pickup(1, -1, TL * TD + 3);
        do_drop(-1, TL * TD + 2);
        do_pickup(1, 15, -1);
        abort_ignored();
        do_pickup(1, -1, -1);
        illegal();
        abort_ignored();
        do_drop(PD - 1, -1);
`ifdef WASHER_SENSE_EN
        do_pickup(0, -1, -1);
        do_pickup(2, -1, -1);
        do_drop(-1, -1);
`endif

        // Reset mid-pickup returns to idle with no pulses.
        bus.start = 1'b1;
        bus.op    = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        RST = 1'b1;
        tick();
        chk("midseq_reset", lv(), LV_IDLE);
        RST = 1'b0;
        mst = 1'b0;
        tick();
        chk("after_reset", lv(), LV_IDLE);

        for (int i = 0; i < 40; i++) begin
            int r;
            int ab;
            int nz;
            r  = int'($urandom_range(0, 9));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, PU - 1)) : -1;
            nz = int'($urandom_range(0, 2 * PU));
            if (!mst) begin
                if (r < 6)      do_pickup(int'($urandom_range(0, MR + 1)), ab, nz);
                else if (r < 8) illegal();
                else            abort_ignored();
            end else begin
                if (r < 6)      do_drop(ab, nz);
                else if (r < 8) illegal();
                else            abort_ignored();
            end
            repeat (int'($urandom_range(0, 3))) tick();
        end

        repeat (3) tick();
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_expectations: %0d pending, required 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
